// File: rtl/pci_arb_pkg.sv
// pci_arb_pkg: shared state type and default sizing for the PCI bus arbiter.
package pci_arb_pkg;

  // Arbiter ownership states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no grant outstanding
    ST_GRANT = 2'd1,  // grant issued, waiting for the owner to start FRAME
    ST_BUSY  = 2'd2,  // owner's transaction in progress
    ST_DEAD  = 2'd3   // one turnaround cycle with every GNT released
  } arb_state_t;

  localparam int PCI_ARB_N_MASTERS_DEF = 3;
  localparam int PCI_ARB_TIMEOUT_DEF   = 16;

endpackage

// File: rtl/pci_rr_picker.sv
// pci_rr_picker: combinational round-robin picker over active-low requests.
// Searches ptr, ptr+1, ... (mod N_MASTERS) and returns the first requester.
module pci_rr_picker
  import pci_arb_pkg::*;
#(
  parameter int N_MASTERS = PCI_ARB_N_MASTERS_DEF,
  localparam int PW = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] REQ,
  input  logic [PW-1:0]        ptr,
  output logic [PW-1:0]        winner,
  output logic                 any
);

  // One extra bit holds ptr+k before the modulo fold (max 2*N_MASTERS-2).
  logic [PW:0] idx;

  // Scan upward from ptr with wraparound and keep the first low request.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_MASTERS)) begin
        idx = idx - (PW+1)'(N_MASTERS);
      end
      if (!any && !REQ[idx[PW-1:0]]) begin
        winner = idx[PW-1:0];
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter: central round-robin PCI arbiter with grant timeout.
// One active-low GNT at a time, always separated by a dead cycle.
// Optional macro PCI_ARB_HIDDEN_EN: hidden arbitration (the owner's grant is
// released mid-transaction as soon as another master requests).
module pci_bus_arbiter
  import pci_arb_pkg::*;
#(
  parameter int N_MASTERS     = PCI_ARB_N_MASTERS_DEF,
  parameter int GRANT_TIMEOUT = PCI_ARB_TIMEOUT_DEF,
  localparam int PW = $clog2(N_MASTERS),
  localparam int CW = $clog2(GRANT_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_MASTERS-1:0] REQ,
  input  logic                 FRAME,
  input  logic                 IRDY,
  output logic [N_MASTERS-1:0] GNT,
  output logic [PW-1:0]        OWNER,
  output logic                 TIMEOUT
);

  arb_state_t    state_reg;
  logic [PW-1:0] ptr_reg;
  logic [CW-1:0] cnt_reg;
  logic          idle_q;

  logic          bus_idle;
  logic          txn_start;
  logic [PW-1:0] pick_winner;
  logic          pick_any;

  // The bus is idle only when both shared strobes are deasserted.
  assign bus_idle  = FRAME & IRDY;
  // A transaction starts on the first FRAME low following an idle cycle.
  assign txn_start = idle_q & ~FRAME;

  pci_rr_picker #(
    .N_MASTERS(N_MASTERS)
  ) u_picker (
    .REQ   (REQ),
    .ptr   (ptr_reg),
    .winner(pick_winner),
    .any   (pick_any)
  );

`ifdef PCI_ARB_HIDDEN_EN
  logic [N_MASTERS-1:0] other_req;
  logic                 others_req;

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_other
    assign other_req[gi] = ~REQ[gi] & (OWNER != PW'(gi));
  end
  assign others_req = |other_req;
`endif

  // Arbitration FSM; GNT, OWNER and TIMEOUT are all registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      GNT       <= '1;
      OWNER     <= '0;
      TIMEOUT   <= 1'b0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      idle_q    <= 1'b1;
    end else begin
      idle_q  <= bus_idle;
      TIMEOUT <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            GNT       <= ~(N_MASTERS'(1) << pick_winner);
            OWNER     <= pick_winner;
            ptr_reg   <= (pick_winner == PW'(N_MASTERS - 1)) ? '0 : pick_winner + 1'b1;
            state_reg <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (txn_start) begin
            state_reg <= ST_BUSY;
            cnt_reg   <= '0;
          end else if (REQ[OWNER]) begin
            // Withdrawal outranks a coincident timeout and gives no pulse.
            GNT       <= '1;
            state_reg <= ST_DEAD;
          end else if (bus_idle && cnt_reg == CW'(GRANT_TIMEOUT - 1)) begin
            GNT       <= '1;
            TIMEOUT   <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= ST_DEAD;
          end else if (bus_idle && cnt_reg != CW'(GRANT_TIMEOUT)) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_BUSY: begin
`ifdef PCI_ARB_HIDDEN_EN
          if (bus_idle || others_req) begin
`else
          if (bus_idle) begin
`endif
            GNT       <= '1;
            state_reg <= ST_DEAD;
          end
        end
        ST_DEAD: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          GNT       <= '1;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
